// File: rtl/dds_modulator_sym.sv
// Symbol-timed carrier modulator: keys a signed DDS carrier with a serial bit
// in OOK (ramped), FSK pass-through, saturating BPSK or LFSR level mode.
module dds_modulator_sym #(
  parameter int DATA_W    = 12,
  parameter int RAMP_LOG2 = 4,
  parameter int SYM_CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [SYM_CNT_W-1:0]     sym_div,
  input  logic [3:0]               modulation,
  input  logic                     bit_in,
  input  logic signed [DATA_W-1:0] in_mod,
  output logic                     sym_tick,
  output logic signed [DATA_W-1:0] out_mod,
  output logic                     mode_err
);
  localparam int PW = DATA_W + RAMP_LOG2 + 1;

  localparam logic [3:0] MODE_OOK  = 4'd0;
  localparam logic [3:0] MODE_FSK  = 4'd1;
  localparam logic [3:0] MODE_BPSK = 4'd2;
  localparam logic [3:0] MODE_LVL  = 4'd3;

  localparam logic [RAMP_LOG2:0]        GAIN_FULL = {1'b1, {RAMP_LOG2{1'b0}}};
  localparam logic signed [DATA_W-1:0]  SMIN      = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [DATA_W-1:0]  SMAX      = {1'b0, {(DATA_W-1){1'b1}}};

  logic [SYM_CNT_W-1:0]     sym_cnt_q, sym_cnt_d;
  logic                     sym_tick_q, sym_tick_d;
  logic [3:0]               cur_mode_q, cur_mode_d;
  logic                     cur_bit_q, cur_bit_d;
  logic [RAMP_LOG2:0]       gain_q, gain_d;
  logic signed [PW-1:0]     s1_q, s1_d;
  logic                     s1_ook_q, s1_ook_d;
  logic signed [DATA_W-1:0] out_q, out_d;
  logic                     mode_err_q, mode_err_d;

  logic signed [PW-1:0]     in_ext, gain_ext, neg_ext, lvl_ext;
  logic signed [DATA_W-1:0] neg_sat;
  logic                     unused_guard;

  // The full-scale product range fits below the guard bit, so it never reaches out_mod.
  assign unused_guard = s1_q[PW-1];

  always_comb begin
    sym_cnt_d  = sym_cnt_q + 1'b1;
    sym_tick_d = 1'b0;
    if (sym_cnt_q >= sym_div) begin
      sym_cnt_d  = '0;
      sym_tick_d = 1'b1;
    end

    cur_mode_d = cur_mode_q;
    cur_bit_d  = cur_bit_q;
    mode_err_d = mode_err_q;
    if (sym_tick_q) begin
      cur_mode_d = modulation;
      cur_bit_d  = bit_in;
      if (modulation > MODE_LVL) mode_err_d = 1'b1;
    end

    // Outside OOK the gain parks at full scale so entering OOK with bit 0 ramps down.
    gain_d = gain_q;
    if (cur_mode_q != MODE_OOK)               gain_d = GAIN_FULL;
    else if (cur_bit_q && gain_q < GAIN_FULL) gain_d = gain_q + 1'b1;
    else if (!cur_bit_q && gain_q != '0)      gain_d = gain_q - 1'b1;

    neg_sat  = (in_mod == SMIN) ? SMAX : -in_mod;
    in_ext   = {{(PW-DATA_W){in_mod[DATA_W-1]}}, in_mod};
    neg_ext  = {{(PW-DATA_W){neg_sat[DATA_W-1]}}, neg_sat};
    lvl_ext  = {{(PW-DATA_W){1'b1}}, SMIN};
    gain_ext = {{(PW-RAMP_LOG2-1){1'b0}}, gain_q};

    s1_d     = '0;
    s1_ook_d = 1'b0;
    case (cur_mode_q)
      MODE_OOK: begin
        s1_d     = in_ext * gain_ext;
        s1_ook_d = 1'b1;
      end
      MODE_FSK:  s1_d = in_ext;
      MODE_BPSK: s1_d = cur_bit_q ? neg_ext : in_ext;
      MODE_LVL:  s1_d = cur_bit_q ? lvl_ext : '0;
      default:   s1_d = '0;
    endcase

    // Taking bits above RAMP_LOG2 is the arithmetic shift with truncation.
    out_d = s1_ook_q ? s1_q[RAMP_LOG2 +: DATA_W] : s1_q[DATA_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sym_cnt_q  <= '0;
      sym_tick_q <= 1'b0;
      cur_mode_q <= MODE_OOK;
      cur_bit_q  <= 1'b0;
      gain_q     <= '0;
      s1_q       <= '0;
      s1_ook_q   <= 1'b0;
      out_q      <= '0;
      mode_err_q <= 1'b0;
    end else begin
      sym_cnt_q  <= sym_cnt_d;
      sym_tick_q <= sym_tick_d;
      cur_mode_q <= cur_mode_d;
      cur_bit_q  <= cur_bit_d;
      gain_q     <= gain_d;
      s1_q       <= s1_d;
      s1_ook_q   <= s1_ook_d;
      out_q      <= out_d;
      mode_err_q <= mode_err_d;
    end
  end

  assign sym_tick = sym_tick_q;
  assign out_mod  = out_q;
  assign mode_err = mode_err_q;
endmodule

// File: tb/tb_dds_modulator_sym.sv
// Directed bench for dds_modulator_sym: symbol timer, OOK ramp, BPSK, FSK,
// LFSR level, boundary-aligned mode change and the sticky mode error.
module tb_dds_modulator_sym;
  logic               clk = 1'b0;
  logic               reset;
  logic [15:0]        sym_div;
  logic [3:0]         modulation;
  logic               bit_in;
  logic signed [11:0] in_mod;
  logic               sym_tick;
  logic signed [11:0] out_mod;
  logic               mode_err;

  int errors = 0;
  int checks = 0;

  // floor(1000 * g / 16) for g = 0..16
  int ook_tab [17] = '{0, 62, 125, 187, 250, 312, 375, 437, 500,
                       562, 625, 687, 750, 812, 875, 937, 1000};

  dds_modulator_sym dut (
    .clk        (clk),
    .reset      (reset),
    .sym_div    (sym_div),
    .modulation (modulation),
    .bit_in     (bit_in),
    .in_mod     (in_mod),
    .sym_tick   (sym_tick),
    .out_mod    (out_mod),
    .mode_err   (mode_err)
  );

  always #5 clk = ~clk;

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_tick(input string tag);
    int n;
    n = 0;
    while (sym_tick !== 1'b1 && n < 200) begin
      clk1();
      n++;
    end
    check({tag, "_tick_timeout"}, {11'd0, sym_tick}, 12'd1);
  endtask

  // Sets mode/bit, waits for a tick and steps past the latching edge.
  task automatic sym(input logic [3:0] m, input logic b, input string tag);
    modulation = m;
    bit_in     = b;
    wait_tick(tag);
    clk1();
  endtask

  // Called right after a latching edge; three samples in, three samples out.
  task automatic pipe3(input string tag,
                       input logic [11:0] v0, input logic [11:0] v1, input logic [11:0] v2,
                       input logic [11:0] e0, input logic [11:0] e1, input logic [11:0] e2);
    in_mod = v0;
    clk1();
    in_mod = v1;
    clk1();
    check({tag, "_0"}, out_mod, e0);
    in_mod = v2;
    clk1();
    check({tag, "_1"}, out_mod, e1);
    clk1();
    check({tag, "_2"}, out_mod, e2);
  endtask

  initial begin
    int g;
    reset      = 1'b1;
    sym_div    = 16'd3;
    modulation = 4'd0;
    bit_in     = 1'b0;
    in_mod     = 12'sd1000;

    // Reset state and symbol timer period
    clk1();
    clk1();
    check("rst_out", out_mod, 12'd0);
    check("rst_tick", {11'd0, sym_tick}, 12'd0);
    check("rst_err", {11'd0, mode_err}, 12'd0);
    reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      clk1();
      check($sformatf("tick_div3_%0d", k), {11'd0, sym_tick}, (k % 4 == 0) ? 12'd1 : 12'd0);
    end

    // OOK ramp up then flip to 0 at gain 8
    sym_div = 16'd7;
    sym(4'd0, 1'b1, "ook_a");
    for (int k = 1; k <= 20; k++) begin
      clk1();
      if (k == 1) bit_in = 1'b0;
      if (k >= 2) begin
        g = k - 2;
        g = (g <= 8) ? g : ((g >= 16) ? 0 : 16 - g);
        check($sformatf("ook_flip_%0d", k), out_mod, 12'(ook_tab[g]));
      end
    end

    // OOK full ramp to 1000 and hold
    sym_div = 16'd31;
    sym(4'd0, 1'b1, "ook_b");
    for (int k = 2; k <= 20; k++) begin
      if (k == 2) clk1();
      clk1();
      g = (k - 2 > 16) ? 16 : k - 2;
      check($sformatf("ook_full_%0d", k), out_mod, 12'(ook_tab[g]));
    end

    // Reset mid-period: counter, gain and output cleared
    reset = 1'b1;
    clk1();
    check("midrst_out", out_mod, 12'd0);
    check("midrst_tick", {11'd0, sym_tick}, 12'd0);
    sym_div = 16'd3;
    reset   = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      clk1();
      check($sformatf("midrst_tick_%0d", k), {11'd0, sym_tick}, (k == 4) ? 12'd1 : 12'd0);
      check($sformatf("midrst_out_%0d", k), out_mod, 12'd0);
    end

    // BPSK
    sym_div = 16'd15;
    sym(4'd2, 1'b1, "bpsk1");
    pipe3("bpsk1", 12'd100, 12'h800, 12'd5, -12'd100, 12'h7FF, -12'd5);
    sym(4'd2, 1'b0, "bpsk0");
    pipe3("bpsk0", 12'd300, 12'h800, -12'd7, 12'd300, 12'h800, -12'd7);

    // LFSR level and FSK
    sym(4'd3, 1'b1, "lvl1");
    pipe3("lvl1", 12'd1, 12'h7FF, 12'h800, 12'h800, 12'h800, 12'h800);
    sym(4'd3, 1'b0, "lvl0");
    pipe3("lvl0", 12'd1, 12'h7FF, 12'h800, 12'h000, 12'h000, 12'h000);
    sym(4'd1, 1'b1, "fsk");
    pipe3("fsk", 12'd1, 12'd2, 12'd3, 12'd1, 12'd2, 12'd3);

    // Mode request changes mid-symbol; takes effect at the next tick
    sym(4'd1, 1'b1, "chg");
    modulation = 4'd2;
    pipe3("chg_fsk", 12'd10, 12'd20, 12'd30, 12'd10, 12'd20, 12'd30);
    wait_tick("chg_bpsk");
    clk1();
    pipe3("chg_bpsk", 12'd10, 12'd20, 12'd30, -12'd10, -12'd20, -12'd30);

    // Illegal mode, then back to a legal one
    sym(4'd9, 1'b1, "ill");
    check("ill_err", {11'd0, mode_err}, 12'd1);
    pipe3("ill", 12'd100, 12'd200, 12'd300, 12'd0, 12'd0, 12'd0);
    sym(4'd1, 1'b0, "legal");
    pipe3("legal", 12'd7, 12'd8, 12'd9, 12'd7, 12'd8, 12'd9);
    check("legal_err_sticky", {11'd0, mode_err}, 12'd1);

    // sym_div = 0: tick every cycle
    sym_div = 16'd0;
    clk1();
    for (int k = 1; k <= 3; k++) begin
      clk1();
      check($sformatf("div0_tick_%0d", k), {11'd0, sym_tick}, 12'd1);
    end

    // Reset clears the sticky error
    reset = 1'b1;
    clk1();
    check("final_rst_err", {11'd0, mode_err}, 12'd0);
    check("final_rst_out", out_mod, 12'd0);
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dds_modulator_sym.md
Name: dds_modulator_sym

Overview:
- Parametrised digital modulator placed between the DDS carrier generator and the output/display path.
- Keys a signed DDS carrier with a serial data bit, using one of several modulation modes.
- Adds features the previous generation lacked:
  - an internal symbol-rate timer that requests bits from the upstream LFSR;
  - mode changes aligned to symbol boundaries;
  - ramped (soft) OOK keying;
  - saturating BPSK negation;
  - an illegal-mode error flag.
- Single clock domain. Any slow-clock crossing is done downstream.

Parameters:
DATA_W, 12, carrier and output sample width (signed two's complement)
RAMP_LOG2, 4, OOK ramp length = 2^RAMP_LOG2 clocks; gain register is RAMP_LOG2+1 bits
SYM_CNT_W, 16, width of symbol period counter

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
sym_div  in  SYM_CNT_W  symbol period minus 1, in clk cycles
modulation  in  4  requested mode: 0 OOK, 1 FSK (pass), 2 BPSK, 3 LFSR level; 4-15 illegal
bit_in  in  1  data bit from LFSR, sampled on sym_tick
in_mod  in  DATA_W  signed carrier sample, one per clk
sym_tick  out  1  one-clk pulse at each symbol boundary; upstream LFSR advances on it
out_mod  out  DATA_W  modulated signed sample
mode_err  out  1  sticky; set when an illegal mode is latched

Behaviour:
- Clocking and reset:
  - All state updates on posedge clk.
  - reset has priority over all other logic, including when asserted mid-operation.
  - Reset values: sym_cnt=0, sym_tick=0, cur_mode=0, cur_bit=0, gain=0, pipeline registers=0, out_mod=0, mode_err=0.
- Symbol timer:
  - If sym_cnt >= sym_div: sym_cnt <= 0 and sym_tick <= 1. Otherwise sym_cnt increments and sym_tick <= 0.
  - With sym_div=0, sym_tick is high every cycle.
  - If sym_div is reduced below the current count, a tick occurs on the next clock.
  - The first tick after reset release comes sym_div+1 clocks later.
- Latching:
  - In the cycle sym_tick is high: cur_bit <= bit_in and cur_mode <= modulation.
  - Mode changes take effect only at symbol boundaries.
  - If the latched mode is 4-15, mode_err <= 1 and stays high until reset.
- Gain ramp (OOK only):
  - Every clock: if cur_bit=1 and gain < 2^RAMP_LOG2, gain +1.
  - Every clock: if cur_bit=0 and gain > 0, gain -1.
  - The ramp saturates at both ends.
  - A bit flip mid-ramp reverses direction from the current gain; there is no restart.
  - In non-OOK modes gain is held at 2^RAMP_LOG2, so a switch into OOK with bit 0 ramps down from full scale.
- Datapath (2-cycle latency; in_mod at clock n appears on out_mod after clock n+2):
  - Stage 1, OOK: prod <= signed(in_mod) * unsigned(gain). Width is DATA_W+RAMP_LOG2+1.
  - Stage 1, other modes: the selected value is registered.
  - Stage 2, OOK: out_mod <= prod >>> RAMP_LOG2 (arithmetic shift, truncation). gain=2^RAMP_LOG2 reproduces in_mod exactly; gain=0 gives 0.
  - FSK: out_mod = in_mod (delayed).
  - BPSK, cur_bit=1: out_mod = -in_mod, saturating. -(-2^(DATA_W-1)) yields 2^(DATA_W-1)-1.
  - BPSK, cur_bit=0: out_mod = in_mod.
  - LFSR level, cur_bit=1: out_mod = {1'b1, (DATA_W-1) zeros}.
  - LFSR level, cur_bit=0: out_mod = 0.
  - Illegal mode: out_mod = 0.
- Simultaneous events:
  - cur_bit, cur_mode and gain all update on the same clock edge.
  - A new bit first affects the stage-1 register on the following edge.

Test Plan:
1. Reset then sym_div=3: sym_tick pulses on every 4th clock; bit_in is sampled only on tick cycles; asserting reset mid-period zeroes sym_cnt, out_mod and gain on the next edge.
2. OOK, in_mod=+1000 constant, bit 0->1: out_mod ramps 0,62,125,...,937,1000 over 16 clocks and holds 1000. Flip to bit 0 at gain=8: output descends from 500 to 0.
3. BPSK, bit=1: in_mod=+100 -> -100; in_mod=-2048 -> +2047 (saturates). bit=0: in_mod passes unchanged with 2-cycle latency.
4. LFSR mode: bit=1 -> 12'h800, bit=0 -> 12'h000. FSK mode: sequence 1,2,3 emerges 2 clocks later unchanged.
5. Change modulation from FSK to BPSK mid-symbol: output stays in FSK until the next sym_tick, then switches.
6. modulation=4'd9 latched on tick: mode_err=1 and out_mod=0. Return to a legal mode: mode_err stays 1 until reset.
